// File: rtl/aes_pkg.sv
// AES-128 key-schedule helpers: S-box, GF(2^8) doubling, schedule constants and FSM states.
// Pure definitions, no logic of its own.
package aes_pkg;

    localparam int         NUM_RK    = 11;
    localparam logic [7:0] RCON_INIT = 8'h01;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        READY
    } ksched_state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[x];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-expansion round: previous round key + rcon -> next round key.
// Latency: purely combinational. Backpressure: none, no handshake.
// Word order: bits[127:96] = w0 ... bits[31:0] = w3.
module aes_key_step
    import aes_pkg::*;
(
    input  logic [127:0] prev_key,
    input  logic [7:0]   rcon,
    output logic [127:0] next_key
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot, t;
    logic [31:0] n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = prev_key;

    // RotWord is a one-byte left rotate, then SubWord per byte.
    assign rot = {w3[23:0], w3[31:24]};
    assign t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
               ^ {rcon, 24'h0};

    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_key_sched_seq.sv
// Iterative AES-128 key expander storing rk0..rk10; zeroize on clear/rst when KSCHED_ZEROIZE_EN is defined.
// Latency: handshake in T, busy T+1..T+10, keys_valid and last_key from T+11; rd_key has 1-cycle read latency.
// Backpressure: key_ready low during expansion, rst and clear; one key per 11 cycles.
module aes_key_sched_seq
    import aes_pkg::*;
#(
    parameter int NUM_RK = aes_pkg::NUM_RK,
    parameter int IDX_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [127:0]     key_in,
    input  logic             key_valid,
    output logic             key_ready,
    output logic             busy,
    output logic             keys_valid,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [127:0]     rd_key,
    output logic [127:0]     last_key
);

`ifdef KSCHED_ZEROIZE_EN
    localparam bit ZEROIZE = 1'b1;
`else
    localparam bit ZEROIZE = 1'b0;
`endif

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RK - 1);

    ksched_state_t    state_q, state_d;
    logic [IDX_W-1:0] cnt;
    logic [7:0]       rcon;
    logic [127:0]     rk [NUM_RK];
    logic [127:0]     prev_key, next_key;
    logic             accept;

    assign accept   = key_valid & key_ready;
    assign prev_key = rk[cnt - IDX_W'(1)];

    aes_key_step u_step (
        .prev_key (prev_key),
        .rcon     (rcon),
        .next_key (next_key)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // rst/clear mask the status outputs in the same cycle so an abort is never seen as progress.
    always_comb begin
        state_d    = state_q;
        key_ready  = 1'b0;
        busy       = 1'b0;
        keys_valid = 1'b0;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    key_ready = 1'b1;
                    if (key_valid) state_d = EXPAND;
                end
                EXPAND: begin
                    busy = 1'b1;
                    if (cnt == LAST_IDX) state_d = READY;
                end
                READY: begin
                    keys_valid = 1'b1;
                    key_ready  = 1'b1;
                    if (key_valid) state_d = EXPAND;
                end
                default: state_d = IDLE;
            endcase
        end
        if (rst) begin
            key_ready  = 1'b0;
            busy       = 1'b0;
            keys_valid = 1'b0;
        end
    end

    // Storage is only cleared in the zeroize build; busy is already low during rst/clear.
    always_ff @(posedge clk) begin
        if (ZEROIZE && (rst || clear)) begin
            for (int i = 0; i < NUM_RK; i++) rk[i] <= '0;
        end else if (accept) begin
            rk[0] <= key_in;
        end else if (busy) begin
            rk[cnt] <= next_key;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            rcon     <= RCON_INIT;
            rd_key   <= '0;
            last_key <= '0;
        end else begin
            rd_key <= (rd_idx <= LAST_IDX) ? rk[rd_idx] : 128'h0;
            if (accept) begin
                cnt  <= IDX_W'(1);
                rcon <= RCON_INIT;
            end else if (busy) begin
                cnt  <= cnt + IDX_W'(1);
                rcon <= xtime(rcon);
            end
            if (ZEROIZE && clear)
                last_key <= '0;
            else if (busy && cnt == LAST_IDX)
                last_key <= next_key;
        end
    end

endmodule

// File: tb/tb_aes_key_sched_seq.sv
// Directed bench for aes_key_sched_seq using FIPS-197 and all-zero key vectors.
module tb_aes_key_sched_seq;

    localparam logic [127:0] FIPS_K   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_R2  = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] FIPS_R9  = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_K   = 128'h0;
    localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_R2  = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
    localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    localparam logic [127:0] OTHER_K  = 128'h000102030405060708090a0b0c0d0e0f;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         clear = 1'b0;
    logic [127:0] key_in = '0;
    logic         key_valid = 1'b0;
    logic         key_ready, busy, keys_valid;
    logic [3:0]   rd_idx = '0;
    logic [127:0] rd_key, last_key;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    aes_key_sched_seq dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .key_in     (key_in),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .busy       (busy),
        .keys_valid (keys_valid),
        .rd_idx     (rd_idx),
        .rd_key     (rd_key),
        .last_key   (last_key)
    );

    // Called at a negedge; returns at the negedge of the cycle after the handshake edge.
    task automatic send_key(input logic [127:0] k, output bit ok);
        key_in    = k;
        key_valid = 1'b1;
        #1 ok = key_ready;
        @(posedge clk);
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    // Counts cycles from the handshake edge until keys_valid, bounded.
    task automatic wait_keys(output int n);
        n = 1;
        while (keys_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic do_read(input logic [3:0] idx, output logic [127:0] v);
        rd_idx = idx;
        @(posedge clk);
        @(negedge clk);
        v = rd_key;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", busy); end
        n_cmp++; if (keys_valid !== 1'b0) begin n_fail++; $display("FAIL rst_keys_valid got=%b exp=0", keys_valid); end
        n_cmp++; if (key_ready !== 1'b0) begin n_fail++; $display("FAIL rst_key_ready got=%b exp=0", key_ready); end
        n_cmp++; if (rd_key !== 128'h0) begin n_fail++; $display("FAIL rst_rd_key got=%h exp=0", rd_key); end
        n_cmp++; if (last_key !== 128'h0) begin n_fail++; $display("FAIL rst_last_key got=%h exp=0", last_key); end
        rst = 1'b0;
        #1;
        n_cmp++; if (key_ready !== 1'b1) begin n_fail++; $display("FAIL idle_key_ready got=%b exp=1", key_ready); end
        @(negedge clk);
    endtask

    task automatic test_fips;
        bit ok; int n; logic [127:0] v;
        send_key(FIPS_K, ok);
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL fips_accept got=%b exp=1", ok); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL fips_busy got=%b exp=1", busy); end
        wait_keys(n);
        n_cmp++; if (n != 11) begin n_fail++; $display("FAIL fips_latency got=%0d exp=11", n); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL fips_busy_done got=%b exp=0", busy); end
        n_cmp++; if (last_key !== FIPS_R10) begin n_fail++; $display("FAIL fips_last_key got=%h exp=%h", last_key, FIPS_R10); end
        do_read(4'd0, v);
        n_cmp++; if (v !== FIPS_K) begin n_fail++; $display("FAIL fips_rk0 got=%h exp=%h", v, FIPS_K); end
        do_read(4'd1, v);
        n_cmp++; if (v !== FIPS_R1) begin n_fail++; $display("FAIL fips_rk1 got=%h exp=%h", v, FIPS_R1); end
        do_read(4'd2, v);
        n_cmp++; if (v !== FIPS_R2) begin n_fail++; $display("FAIL fips_rk2 got=%h exp=%h", v, FIPS_R2); end
        do_read(4'd9, v);
        n_cmp++; if (v !== FIPS_R9) begin n_fail++; $display("FAIL fips_rk9 got=%h exp=%h", v, FIPS_R9); end
        do_read(4'd10, v);
        n_cmp++; if (v !== FIPS_R10) begin n_fail++; $display("FAIL fips_rk10 got=%h exp=%h", v, FIPS_R10); end
        do_read(4'd11, v);
        n_cmp++; if (v !== 128'h0) begin n_fail++; $display("FAIL rd_idx11 got=%h exp=0", v); end
        do_read(4'd15, v);
        n_cmp++; if (v !== 128'h0) begin n_fail++; $display("FAIL rd_idx15 got=%h exp=0", v); end
    endtask

    task automatic test_zero_key;
        bit ok; int n; logic [127:0] v;
        send_key(ZERO_K, ok);
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL zero_accept got=%b exp=1", ok); end
        n_cmp++; if (keys_valid !== 1'b0) begin n_fail++; $display("FAIL zero_kv_fall got=%b exp=0", keys_valid); end
        wait_keys(n);
        n_cmp++; if (n != 11) begin n_fail++; $display("FAIL zero_latency got=%0d exp=11", n); end
        n_cmp++; if (last_key !== ZERO_R10) begin n_fail++; $display("FAIL zero_last_key got=%h exp=%h", last_key, ZERO_R10); end
        do_read(4'd1, v);
        n_cmp++; if (v !== ZERO_R1) begin n_fail++; $display("FAIL zero_rk1 got=%h exp=%h", v, ZERO_R1); end
        do_read(4'd2, v);
        n_cmp++; if (v !== ZERO_R2) begin n_fail++; $display("FAIL zero_rk2 got=%h exp=%h", v, ZERO_R2); end
        do_read(4'd10, v);
        n_cmp++; if (v !== ZERO_R10) begin n_fail++; $display("FAIL zero_rk10 got=%h exp=%h", v, ZERO_R10); end
    endtask

    task automatic test_valid_during_expand;
        int zr = 0;
        key_in    = FIPS_K;
        key_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        key_in = OTHER_K;
        for (int i = 0; i < 10; i++) begin
            if (key_ready === 1'b0) zr++;
            if (i == 9) key_valid = 1'b0;
            @(negedge clk);
        end
        n_cmp++; if (zr != 10) begin n_fail++; $display("FAIL hold_ready_low got=%0d exp=10", zr); end
        n_cmp++; if (keys_valid !== 1'b1) begin n_fail++; $display("FAIL hold_keys_valid got=%b exp=1", keys_valid); end
        n_cmp++; if (last_key !== FIPS_R10) begin n_fail++; $display("FAIL hold_last_key got=%h exp=%h", last_key, FIPS_R10); end
    endtask

    task automatic test_clear_mid;
        bit ok; int n; int seen = 0; logic [127:0] v;
        send_key(FIPS_K, ok);
        repeat (4) @(negedge clk);
        clear = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clr_busy got=%b exp=0", busy); end
        n_cmp++; if (key_ready !== 1'b0) begin n_fail++; $display("FAIL clr_key_ready got=%b exp=0", key_ready); end
        @(posedge clk);
        @(negedge clk);
        clear = 1'b0;
        #1;
        n_cmp++; if (key_ready !== 1'b1) begin n_fail++; $display("FAIL clr_idle_ready got=%b exp=1", key_ready); end
        for (int i = 0; i < 15; i++) begin
            if (keys_valid !== 1'b0 || busy !== 1'b0) seen++;
            @(negedge clk);
        end
        n_cmp++; if (seen != 0) begin n_fail++; $display("FAIL clr_stays_idle got=%0d exp=0", seen); end
        send_key(ZERO_K, ok);
        wait_keys(n);
        n_cmp++; if (n != 11) begin n_fail++; $display("FAIL clr_new_latency got=%0d exp=11", n); end
        n_cmp++; if (last_key !== ZERO_R10) begin n_fail++; $display("FAIL clr_new_last_key got=%h exp=%h", last_key, ZERO_R10); end
        do_read(4'd1, v);
        n_cmp++; if (v !== ZERO_R1) begin n_fail++; $display("FAIL clr_new_rk1 got=%h exp=%h", v, ZERO_R1); end
    endtask

    task automatic test_clear_handshake;
        logic [127:0] v; int nz = 0;
        clear     = 1'b1;
        key_valid = 1'b1;
        key_in    = FIPS_K;
        #1;
        n_cmp++; if (key_ready !== 1'b0) begin n_fail++; $display("FAIL clrhs_ready got=%b exp=0", key_ready); end
        @(posedge clk);
        @(negedge clk);
        clear     = 1'b0;
        key_valid = 1'b0;
        #1;
        n_cmp++; if (keys_valid !== 1'b0) begin n_fail++; $display("FAIL clrhs_kv got=%b exp=0", keys_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clrhs_busy got=%b exp=0", busy); end
        repeat (3) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clrhs_not_taken got=%b exp=0", busy); end
`ifdef KSCHED_ZEROIZE_EN
        for (int i = 0; i <= 10; i++) begin
            do_read(4'(i), v);
            if (v !== 128'h0) nz++;
        end
        n_cmp++; if (nz != 0) begin n_fail++; $display("FAIL zeroize_reads got=%0d nonzero exp=0", nz); end
        n_cmp++; if (last_key !== 128'h0) begin n_fail++; $display("FAIL zeroize_last_key got=%h exp=0", last_key); end
`else
        do_read(4'd10, v);
        n_cmp++; if (v !== ZERO_R10) begin n_fail++; $display("FAIL stale_rk10 got=%h exp=%h", v, ZERO_R10); end
        n_cmp++; if (last_key !== ZERO_R10) begin n_fail++; $display("FAIL stale_last_key got=%h exp=%h", last_key, ZERO_R10); end
        n_cmp++; if (nz != 0) begin n_fail++; $display("FAIL stale_nz got=%0d exp=0", nz); end
`endif
    endtask

    task automatic test_back_to_back;
        bit ok; int n; int seen = 0;
        send_key(FIPS_K, ok);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (key_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready got=%b exp=0", key_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        n_cmp++; if (last_key !== 128'h0) begin n_fail++; $display("FAIL rstmid_last_key got=%h exp=0", last_key); end
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (keys_valid !== 1'b0) seen++;
            @(negedge clk);
        end
        n_cmp++; if (seen != 0) begin n_fail++; $display("FAIL rstmid_no_valid got=%0d exp=0", seen); end
        send_key(ZERO_K, ok);
        wait_keys(n);
        n_cmp++; if (n != 11) begin n_fail++; $display("FAIL b2b_first_latency got=%0d exp=11", n); end
        send_key(FIPS_K, ok);
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL b2b_accept got=%b exp=1", ok); end
        wait_keys(n);
        n_cmp++; if (n != 11) begin n_fail++; $display("FAIL b2b_latency got=%0d exp=11", n); end
        n_cmp++; if (last_key !== FIPS_R10) begin n_fail++; $display("FAIL b2b_last_key got=%h exp=%h", last_key, FIPS_R10); end
    endtask

    initial begin
        test_reset();
        test_fips();
        test_zero_key();
        test_valid_during_expand();
        test_clear_mid();
        test_clear_handshake();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
